// File: rtl/pong_pkg.sv
// pong_pkg -- shared definitions for the pong match controller.
//   state_e      : match FSM states, in display-code order 0..4
//   MODE_*       : match mode encodings carried on the mode input
//   WIN_*        : winner output encodings
//   SIDE_*       : side identifiers used for the point scorer
//   idx_w()      : bit width needed to index n positions (at least 1)
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam logic MODE_RALLY  = 1'b0;
   localparam logic MODE_VERSUS = 1'b1;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;
   localparam logic [1:0] WIN_RALLY = 2'b11;

   localparam logic SIDE_LEFT  = 1'b0;
   localparam logic SIDE_RIGHT = 1'b1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pong_edge_check.sv
// pong_edge_check -- collision detector for one side of the field.
// Owns the column compare and the arm flag: one event per visit of the ball
// to the paddle column, re-armed once the ball leaves the column.
//   clk        : clock
//   reset      : asynchronous, active-low reset (arm flag returns to 1)
//   en_i       : checks enabled (match in play and ball moving)
//   ball_x_i   : ball column
//   mask_bit_i : paddle occupancy at the ball's row
//   hit_o      : combinational strobe, event with paddle present
//   miss_o     : combinational strobe, event with paddle absent
module pong_edge_check #(
   parameter int XW         = 6,
   parameter int FIELD_W    = 64,
   parameter bit RIGHT_SIDE = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic [XW-1:0] ball_x_i,
   input  logic          mask_bit_i,
   output logic          hit_o,
   output logic          miss_o
);

   localparam logic [XW-1:0] COL = RIGHT_SIDE ? XW'(FIELD_W - 2) : XW'(1);

   logic in_col;
   logic evt;
   logic arm_q, arm_d;

   // The right column also covers the last column, so a ball that skips
   // past FIELD_W-2 in one step is still seen.
   assign in_col = RIGHT_SIDE ? (ball_x_i >= COL) : (ball_x_i == COL);
   assign evt    = en_i & in_col & arm_q;
   assign hit_o  = evt & mask_bit_i;
   assign miss_o = evt & ~mask_bit_i;

   always_comb begin
      arm_d = arm_q;
      if (!in_col) begin
         arm_d = 1'b1;
      end else if (evt) begin
         arm_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arm_q <= 1'b1;
      end else begin
         arm_q <= arm_d;
      end
   end

endmodule

// File: rtl/pong_referee.sv
// pong_referee -- match controller between the paddle/ball blocks and the
// scoreboard. Detects paddle hits and misses, pulses hits back to the ball,
// holds the ball in reset between points, keeps both scores and runs the
// idle/serve/play/point/over match sequence. All outputs are registered.
//   clk, reset            : clock, asynchronous active-low reset
//   start                 : begin a match from IDLE or OVER
//   mode                  : 1 = versus, 0 = rally (sampled at match start)
//   ball_moving           : ball block reports motion
//   ball_x, ball_y        : ball position
//   left_mask, right_mask : paddle occupancy, bit i = row i
//   hit_left, hit_right   : one-cycle bounce pulses
//   ball_reset_n          : active-low reset to ball and paddles
//   left_score, right_score, winner, state_o : scoreboard / display
// Build option: define PONG_WIN_BY_TWO_EN to require a two-point lead for a
// versus win (a side reaching the top score value wins outright).
module pong_referee
   import pong_pkg::*;
#(
   parameter int  FIELD_W     = 64,
   parameter int  FIELD_H     = 32,
   parameter int  SCORE_W     = 4,
   parameter int  WIN_SCORE   = 9,
   parameter int  SERVE_DELAY = 16,
   localparam int XW          = idx_w(FIELD_W),
   localparam int YW          = idx_w(FIELD_H)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic               ball_moving,
   input  logic [XW-1:0]      ball_x,
   input  logic [YW-1:0]      ball_y,
   input  logic [FIELD_H-1:0] left_mask,
   input  logic [FIELD_H-1:0] right_mask,
   output logic               hit_left,
   output logic               hit_right,
   output logic               ball_reset_n,
   output logic [SCORE_W-1:0] left_score,
   output logic [SCORE_W-1:0] right_score,
   output logic [1:0]         winner,
   output logic [2:0]         state_o
);

   localparam int                 CW         = idx_w(SERVE_DELAY);
   localparam logic [CW-1:0]      SERVE_LOAD = CW'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
   logic [1:0]         winner_q, winner_d;
   logic               mode_q, mode_d;
   logic               scorer_q, scorer_d;
   logic               hit_left_q, hit_right_q, ball_reset_n_q;
   logic               play_en, r_en;
   logic               l_hit, l_miss, r_hit, r_miss;
   logic [SCORE_W-1:0] pt_score, pt_other;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + 1'b1;
   endfunction

   function automatic logic is_win(input logic [SCORE_W-1:0] s,
                                   input logic [SCORE_W-1:0] o);
`ifdef PONG_WIN_BY_TWO_EN
      return (s == SCORE_MAX) ||
             ((int'(s) >= WIN_SCORE) && (int'(s) >= int'(o) + 2));
`else
      // While play continues the other side is necessarily below WIN_SCORE.
      return (int'(s) == WIN_SCORE) && (int'(o) < WIN_SCORE);
`endif
   endfunction

   assign play_en = (state_q == ST_PLAY) && ball_moving;
   // Left has priority if both columns ever coincide on a tiny field.
   assign r_en    = play_en & ~(l_hit | l_miss);

   pong_edge_check #(.XW(XW), .FIELD_W(FIELD_W), .RIGHT_SIDE(1'b0)) u_left (
      .clk        (clk),
      .reset      (reset),
      .en_i       (play_en),
      .ball_x_i   (ball_x),
      .mask_bit_i (left_mask[ball_y]),
      .hit_o      (l_hit),
      .miss_o     (l_miss)
   );

   pong_edge_check #(.XW(XW), .FIELD_W(FIELD_W), .RIGHT_SIDE(1'b1)) u_right (
      .clk        (clk),
      .reset      (reset),
      .en_i       (r_en),
      .ball_x_i   (ball_x),
      .mask_bit_i (right_mask[ball_y]),
      .hit_o      (r_hit),
      .miss_o     (r_miss)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lscore_d = lscore_q;
      rscore_d = rscore_q;
      winner_d = winner_q;
      mode_d   = mode_q;
      scorer_d = scorer_q;
      pt_score = (scorer_q == SIDE_LEFT) ? sat_inc(lscore_q) : sat_inc(rscore_q);
      pt_other = (scorer_q == SIDE_LEFT) ? rscore_q : lscore_q;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               lscore_d = '0;
               rscore_d = '0;
               winner_d = WIN_NONE;
               mode_d   = mode;
               cnt_d    = SERVE_LOAD;
               state_d  = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (cnt_q == '0) begin
               state_d = ST_PLAY;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PLAY: begin
            if (mode_q == MODE_RALLY) begin
               if (l_hit) lscore_d = sat_inc(lscore_q);
               if (r_hit) rscore_d = sat_inc(rscore_q);
            end
            // A miss on one side is a point for the other.
            if (l_miss) begin
               scorer_d = SIDE_RIGHT;
               state_d  = ST_POINT;
            end else if (r_miss) begin
               scorer_d = SIDE_LEFT;
               state_d  = ST_POINT;
            end
         end
         ST_POINT: begin
            if (mode_q == MODE_RALLY) begin
               winner_d = WIN_RALLY;
               state_d  = ST_OVER;
            end else begin
               if (scorer_q == SIDE_LEFT) lscore_d = pt_score;
               else                       rscore_d = pt_score;
               if (is_win(pt_score, pt_other)) begin
                  winner_d = (scorer_q == SIDE_LEFT) ? WIN_LEFT : WIN_RIGHT;
                  state_d  = ST_OVER;
               end else begin
                  cnt_d   = SERVE_LOAD;
                  state_d = ST_SERVE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         lscore_q       <= '0;
         rscore_q       <= '0;
         winner_q       <= WIN_NONE;
         mode_q         <= MODE_RALLY;
         scorer_q       <= SIDE_LEFT;
         hit_left_q     <= 1'b0;
         hit_right_q    <= 1'b0;
         ball_reset_n_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lscore_q       <= lscore_d;
         rscore_q       <= rscore_d;
         winner_q       <= winner_d;
         mode_q         <= mode_d;
         scorer_q       <= scorer_d;
         hit_left_q     <= l_hit;
         hit_right_q    <= r_hit;
         // Registered from the next state so it tracks state_o exactly.
         ball_reset_n_q <= (state_d == ST_PLAY);
      end
   end

   assign hit_left     = hit_left_q;
   assign hit_right    = hit_right_q;
   assign ball_reset_n = ball_reset_n_q;
   assign left_score   = lscore_q;
   assign right_score  = rscore_q;
   assign winner       = winner_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_pong_referee.sv
module tb_pong_referee;

   localparam int FIELD_W     = 64;
   localparam int FIELD_H     = 32;
   localparam int SCORE_W     = 4;
   localparam int WIN_SCORE   = 9;
   localparam int SERVE_DELAY = 16;
   localparam int XW          = 6;
   localparam int YW          = 5;
   localparam int SMAX        = (1 << SCORE_W) - 1;

   // display codes on state_o
   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               mode;
   logic               ball_moving;
   logic [XW-1:0]      ball_x;
   logic [YW-1:0]      ball_y;
   logic [FIELD_H-1:0] left_mask;
   logic [FIELD_H-1:0] right_mask;
   logic               hit_left;
   logic               hit_right;
   logic               ball_reset_n;
   logic [SCORE_W-1:0] left_score;
   logic [SCORE_W-1:0] right_score;
   logic [1:0]         winner;
   logic [2:0]         state_o;

   pong_referee #(
      .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .SCORE_W(SCORE_W),
      .WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .ball_moving(ball_moving), .ball_x(ball_x), .ball_y(ball_y),
      .left_mask(left_mask), .right_mask(right_mask),
      .hit_left(hit_left), .hit_right(hit_right), .ball_reset_n(ball_reset_n),
      .left_score(left_score), .right_score(right_score),
      .winner(winner), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int hl_cnt = 0;
   int hr_cnt = 0;

   // pulse counters, sampled on the inactive edge
   always @(negedge clk) begin
      if (reset) begin
         if (hit_left)  hl_cnt++;
         if (hit_right) hr_cnt++;
      end
   end

   initial begin
      #900_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- reference model (event level) ----------------
   int m_l, m_r, m_win, m_hl, m_hr, base_hl, base_hr;
   bit m_mode, m_over;

   function automatic bit won(input int s, input int o);
`ifdef PONG_WIN_BY_TWO_EN
      return (s == SMAX) || (s >= WIN_SCORE && s - o >= 2);
`else
      return (s == WIN_SCORE) && (o < WIN_SCORE);
`endif
   endfunction

   task automatic model_start(input bit m);
      m_mode = m; m_over = 0; m_l = 0; m_r = 0; m_win = 0;
      m_hl = 0; m_hr = 0; base_hl = hl_cnt; base_hr = hr_cnt;
   endtask

   task automatic model_visit(input bit right, input bit hit, input bit moving);
      if (m_over || !moving) return;
      if (hit) begin
         if (right) m_hr++; else m_hl++;
         if (!m_mode) begin
            if (right) m_r = (m_r < SMAX) ? m_r + 1 : SMAX;
            else       m_l = (m_l < SMAX) ? m_l + 1 : SMAX;
         end
      end else if (!m_mode) begin
         m_win = 3; m_over = 1;
      end else if (right) begin
         m_l++;
         if (won(m_l, m_r)) begin m_win = 1; m_over = 1; end
      end else begin
         m_r++;
         if (won(m_r, m_l)) begin m_win = 2; m_over = 1; end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_lscore"}, int'(left_score), m_l);
      chk({tag, "_rscore"}, int'(right_score), m_r);
      chk({tag, "_winner"}, int'(winner), m_win);
      chk({tag, "_state"}, int'(state_o), m_over ? S_OVER : S_PLAY);
      chk({tag, "_hits_l"}, hl_cnt - base_hl, m_hl);
      chk({tag, "_hits_r"}, hr_cnt - base_hr, m_hr);
   endtask

   task automatic wait_settle();
      int n;
      n = 0;
      while (!(int'(state_o) == S_PLAY || int'(state_o) == S_OVER) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("settle_timeout", n, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0; start = 1'b0; mode = 1'b0; ball_moving = 1'b0;
      ball_x = XW'(32); ball_y = '0; left_mask = '0; right_mask = '0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic start_match(input bit m);
      ball_x = XW'(32);
      mode = m; start = 1'b1;
      tick();
      start = 1'b0;
      wait_settle();
   endtask

   task automatic visit(input bit right, input bit hit, input bit moving, input int linger);
      logic [YW-1:0]      y;
      logic [FIELD_H-1:0] msk;
      y = YW'($urandom_range(0, FIELD_H - 1));
      msk = FIELD_H'($urandom);
      msk[y] = hit;
      ball_y = y;
      ball_moving = moving;
      if (right) begin
         right_mask = msk; left_mask = FIELD_H'($urandom);
         ball_x = XW'(FIELD_W - 2 + int'($urandom_range(0, 1)));
      end else begin
         left_mask = msk; right_mask = FIELD_H'($urandom);
         ball_x = XW'(1);
      end
      repeat (linger) tick();
      ball_x = XW'($urandom_range(2, FIELD_W - 3));
      tick();
      wait_settle();
   endtask

   typedef struct {
      bit right; bit hit;
      int el; int er; int ew; int ehl; int ehr;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int n, b;
      tbl[0] = '{0, 1, 0, 0, 0, 1, 0};
      tbl[1] = '{1, 1, 0, 0, 0, 1, 1};
      tbl[2] = '{0, 0, 0, 1, 0, 1, 1};
      tbl[3] = '{1, 0, 1, 1, 0, 1, 1};
      tbl[4] = '{1, 0, 2, 1, 0, 1, 1};
      tbl[5] = '{0, 1, 2, 1, 0, 2, 1};
      tbl[6] = '{0, 0, 2, 2, 0, 2, 1};
      tbl[7] = '{1, 1, 2, 2, 0, 2, 2};

      // reset values
      do_reset();
      reset = 1'b0;
      tick();
      chk("rst_state", int'(state_o), S_IDLE);
      chk("rst_lscore", int'(left_score), 0);
      chk("rst_rscore", int'(right_score), 0);
      chk("rst_winner", int'(winner), 0);
      chk("rst_brn", int'(ball_reset_n), 0);
      chk("rst_hitl", int'(hit_left), 0);
      chk("rst_hitr", int'(hit_right), 0);
      reset = 1'b1;
      tick();

      // serve length
      mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!ball_reset_n && n < 100) begin n++; tick(); end
      chk("serve_len", n, SERVE_DELAY);
      chk("serve_play", int'(state_o), S_PLAY);

      // one pulse per visit
      left_mask = '1; ball_y = YW'(7); ball_moving = 1'b1; b = hl_cnt;
      ball_x = XW'(1);
      tick();
      chk("hold_pulse1", int'(hit_left), 1);
      tick();
      chk("hold_pulse0", int'(hit_left), 0);
      tick(); tick(); tick();
      chk("hold_count", hl_cnt - b, 1);
      ball_x = XW'(30); tick();
      ball_x = XW'(1);  tick();
      chk("rearm_pulse", int'(hit_left), 1);
      ball_x = XW'(30); tick();
      chk("rearm_count", hl_cnt - b, 2);
      chk("versus_hit_noscore", int'(left_score), 0);

      // right miss at column 62
      right_mask = '0; ball_x = XW'(62);
      tick();
      ball_x = XW'(30);
      chk("miss_point", int'(state_o), S_POINT);
      chk("miss_score_lat", int'(left_score), 0);
      n = 0;
      while (!ball_reset_n && n < 100) begin n++; tick(); end
      chk("miss_brn_low", n, 1 + SERVE_DELAY);
      chk("miss_lscore", int'(left_score), 1);
      chk("miss_replay", int'(state_o), S_PLAY);

      // asynchronous reset mid-serve
      ball_x = XW'(62); tick();
      ball_x = XW'(30); tick(); tick(); tick();
      chk("pre_rst_serve", int'(state_o), S_SERVE);
      chk("pre_rst_lscore", int'(left_score), 2);
      reset = 1'b0;
      #2;
      chk("arst_state", int'(state_o), S_IDLE);
      chk("arst_lscore", int'(left_score), 0);
      chk("arst_brn", int'(ball_reset_n), 0);
      chk("arst_winner", int'(winner), 0);
      do_reset();

      // table-driven versus sequence
      start_match(1'b1);
      b = hl_cnt; n = hr_cnt;
      for (int i = 0; i < 8; i++) begin
         visit(tbl[i].right, tbl[i].hit, 1'b1, 2);
         chk($sformatf("tbl%0d_l", i), int'(left_score), tbl[i].el);
         chk($sformatf("tbl%0d_r", i), int'(right_score), tbl[i].er);
         chk($sformatf("tbl%0d_w", i), int'(winner), tbl[i].ew);
         chk($sformatf("tbl%0d_st", i), int'(state_o), S_PLAY);
         chk($sformatf("tbl%0d_hl", i), hl_cnt - b, tbl[i].ehl);
         chk($sformatf("tbl%0d_hr", i), hr_cnt - n, tbl[i].ehr);
      end
      do_reset();

      // nine left points, then stimulus ignored in OVER
      start_match(1'b1);
      for (int i = 0; i < 9; i++) visit(1'b1, 1'b0, 1'b1, 1);
      chk("nine_lscore", int'(left_score), 9);
      chk("nine_winner", int'(winner), 1);
      chk("nine_state", int'(state_o), S_OVER);
      b = hl_cnt;
      visit(1'b1, 1'b0, 1'b1, 2);
      visit(1'b0, 1'b1, 1'b1, 2);
      chk("over_lscore", int'(left_score), 9);
      chk("over_rscore", int'(right_score), 0);
      chk("over_state", int'(state_o), S_OVER);
      chk("over_nohit", hl_cnt - b, 0);
      chk("over_brn", int'(ball_reset_n), 0);

      // rally: three left hits then a right miss
      start_match(1'b0);
      ball_moving = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         ball_y = YW'(3); left_mask = FIELD_H'(1) << 3; ball_x = XW'(1);
         tick();
         chk($sformatf("rally_score%0d", k), int'(left_score), k);
         chk($sformatf("rally_pulse%0d", k), int'(hit_left), 1);
         ball_x = XW'(30);
         tick();
      end
      right_mask = '0; ball_x = XW'(63);
      tick();
      chk("rally_point", int'(state_o), S_POINT);
      tick();
      ball_x = XW'(30);
      chk("rally_over", int'(state_o), S_OVER);
      chk("rally_winner", int'(winner), 3);
      chk("rally_lscore", int'(left_score), 3);

      // mode held for the match
      start_match(1'b1);
      mode = 1'b0;
      visit(1'b0, 1'b1, 1'b1, 1);
      chk("mode_hold_hit", int'(left_score), 0);
      visit(1'b1, 1'b0, 1'b1, 1);
      chk("mode_hold_pt", int'(left_score), 1);
      chk("mode_hold_st", int'(state_o), S_PLAY);
      do_reset();

      // rally saturation
      start_match(1'b0);
      for (int i = 0; i < SMAX + 2; i++) visit(1'b0, 1'b1, 1'b1, 1);
      chk("sat_lscore", int'(left_score), SMAX);
      visit(1'b1, 1'b0, 1'b1, 1);
      chk("sat_winner", int'(winner), 3);

      // close finish 9-8 / 10-8
      start_match(1'b1);
      for (int i = 0; i < 8; i++) begin
         visit(1'b1, 1'b0, 1'b1, 1);
         visit(1'b0, 1'b0, 1'b1, 1);
      end
      visit(1'b1, 1'b0, 1'b1, 1);
`ifdef PONG_WIN_BY_TWO_EN
      chk("w2_98_winner", int'(winner), 0);
      chk("w2_98_state", int'(state_o), S_PLAY);
      visit(1'b1, 1'b0, 1'b1, 1);
      chk("w2_108_winner", int'(winner), 1);
      chk("w2_108_lscore", int'(left_score), 10);
      chk("w2_108_state", int'(state_o), S_OVER);
`else
      chk("w1_98_winner", int'(winner), 1);
      chk("w1_98_rscore", int'(right_score), 8);
      chk("w1_98_state", int'(state_o), S_OVER);
`endif

      // randomized matches against the model
      for (int mt = 0; mt < 16; mt++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         start_match(m);
         model_start(m);
         for (int v = 0; v < 30 && !m_over; v++) begin
            bit r, h, mv;
            int lg;
            r  = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 9) < (m ? 5 : 8));
            mv = ($urandom_range(0, 7) != 0);
            lg = $urandom_range(1, 4);
            visit(r, h, mv, lg);
            model_visit(r, h, mv);
            check_model($sformatf("rnd%0d_%0d", mt, v));
         end
         if (!m_over) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
